// File: rtl/pov_column_reader.sv
// rtl/pov_column_reader.sv - POV column RAM sweep reader with latency-compensated credit FIFO
module pov_column_reader #(
    parameter int DAT_WIDTH  = 36,
    parameter int ADDR_WIDTH = 7,
    parameter int NUM_COLS   = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sync,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic [ADDR_WIDTH-1:0] rdaddress,
    input  logic [DAT_WIDTH-1:0]  q,
    output logic [DAT_WIDTH-1:0]  col_data,
    output logic                  col_valid,
    input  logic                  col_ready,
    output logic                  col_last,
    output logic                  busy,
    output logic                  overrun
);
    localparam int RW = ADDR_WIDTH + 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
    localparam logic [RW-1:0] NUM_COLS_R = RW'(NUM_COLS);
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_MAX    = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state, state_nxt;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [RW-1:0]          remaining;
    // tag_v[0]: rdaddress holds an issued address; tag_v[2]: q carries that word now
    logic [2:0]             tag_v, tag_l;
    logic [DAT_WIDTH-1:0]   fifo_d [FIFO_DEPTH];
    logic                   fifo_l [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count, inflight, occupancy;
    logic                   accept, issue, issue_last, push, pop;

    assign col_valid = (count != '0);
    assign col_data  = fifo_d[rd_ptr];
    assign col_last  = col_valid & fifo_l[rd_ptr];
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        accept     = (state == IDLE) && sync;
        pop        = col_valid && col_ready;
        push       = tag_v[2];
        inflight   = CW'(tag_v[0]) + CW'(tag_v[1]) + CW'(tag_v[2]);
        // Slots that stay committed after this edge; a pop this cycle frees one.
        occupancy  = count + inflight - CW'(pop);
        issue      = accept || ((state == RUN) && (remaining != '0) && (occupancy < DEPTH_C));
        issue_last = issue && (accept ? (NUM_COLS == 1) : (remaining == RW'(1)));
        case (state)
            IDLE:  if (accept) state_nxt = (NUM_COLS == 1) ? DRAIN : RUN;
            RUN:   if (issue_last) state_nxt = DRAIN;
            DRAIN: if ((inflight == '0) && ((count - CW'(pop)) == '0)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            rdaddress <= '0;
            tag_v     <= '0;
            tag_l     <= '0;
            overrun   <= 1'b0;
        end else begin
            state <= state_nxt;
            tag_v <= {tag_v[1:0], issue};
            tag_l <= {tag_l[1:0], issue_last};
            if (sync && (state != IDLE)) overrun <= 1'b1;
            // The sync cycle itself issues base_addr so the first word lands at sync+4.
            if (accept) begin
                rdaddress <= base_addr;
                addr      <= base_addr + ADDR_WIDTH'(1);
                remaining <= NUM_COLS_R - RW'(1);
            end else if (issue) begin
                rdaddress <= addr;
                addr      <= addr + ADDR_WIDTH'(1);
                remaining <= remaining - RW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_d[i] <= '0;
                fifo_l[i] <= 1'b0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr] <= q;
                fifo_l[wr_ptr] <= tag_l[2];
                wr_ptr         <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_pov_column_reader.sv
// tb/tb_pov_column_reader.sv - directed table-driven bench for pov_column_reader
module tb_pov_column_reader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sync_a, sync_b, ready_a, ready_b;
    logic [6:0]  base_a, base_b, rdaddr_a, rdaddr_b, ra_a, ra_b;
    logic [35:0] q_a, q_b, data_a, data_b;
    logic        valid_a, valid_b, last_a, last_b, busy_a, busy_b, ovr_a, ovr_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pov_column_reader dut_a (
        .clk(clk), .rst_n(rst_n), .sync(sync_a), .base_addr(base_a), .rdaddress(rdaddr_a),
        .q(q_a), .col_data(data_a), .col_valid(valid_a), .col_ready(ready_a),
        .col_last(last_a), .busy(busy_a), .overrun(ovr_a)
    );

    pov_column_reader #(.NUM_COLS(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .sync(sync_b), .base_addr(base_b), .rdaddress(rdaddr_b),
        .q(q_b), .col_data(data_b), .col_valid(valid_b), .col_ready(ready_b),
        .col_last(last_b), .busy(busy_b), .overrun(ovr_b)
    );

    function automatic logic [35:0] memv(input logic [6:0] a);
        return {29'h0, a} ^ 36'hA5A5A5A5A;
    endfunction

    // two-cycle RAM: registered address then registered output
    always @(posedge clk) begin
        ra_a <= rdaddr_a;
        q_a  <= memv(ra_a);
        ra_b <= rdaddr_b;
        q_b  <= memv(ra_b);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // held-data check whenever the sink stalls a valid beat
    logic        stall_a = 1'b0;
    logic [35:0] held_d;
    logic        held_l;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_a = 1'b0;
        end else begin
            if (stall_a) begin
                chk("stall_valid", 64'(valid_a), 64'd1);
                chk("stall_data", 64'(data_a), 64'(held_d));
                chk("stall_last", 64'(last_a), 64'(held_l));
            end
            stall_a = valid_a & ~ready_a;
            held_d  = data_a;
            held_l  = last_a;
        end
    end

    typedef struct {
        logic [6:0]  base;
        int          mode;
        int          extra_sync;
        int          exp_n;
        int          exp_lat;
        logic [35:0] exp_first;
        logic [35:0] exp_last;
        logic        exp_ovr;
    } sweep_vec_t;

    // Entered at posedge+1 of the sync cycle; returns at posedge+1 of the cycle busy falls.
    task automatic sweep_a(input sweep_vec_t v);
        int  beats = 0;
        int  lat = -1;
        bit  done = 0;
        logic [35:0] first_d = '0, last_d = '0;
        sync_a = 1'b1;
        base_a = v.base;
        ready_a = 1'b1;
        @(posedge clk); #1;
        for (int cyc = 1; cyc < 2000 && !done; cyc++) begin
            if (cyc == 1) chk("busy_rise", 64'(busy_a), 64'd1);
            sync_a = (cyc == v.extra_sync);
            if (v.mode == 2) begin
                if (cyc == 50) chk("credit_stall_addr", 64'(rdaddr_a), 64'(7'(v.base + 7'(beats) + 7'd3)));
                ready_a = (cyc < 30) ? 1'b1 : (cyc < 50) ? 1'b0 : 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (valid_a && ready_a) begin
                if (beats == 0) begin lat = cyc; first_d = data_a; end
                chk("beat_data", 64'(data_a), 64'(memv(7'(v.base + 7'(beats)))));
                chk("beat_last", 64'(last_a), 64'(beats == v.exp_n - 1));
                last_d = data_a;
                beats++;
                if (beats == v.exp_n) done = 1;
            end
            @(posedge clk); #1;
        end
        sync_a = 1'b0;
        ready_a = 1'b1;
        chk("sweep_done", 64'(done), 64'd1);
        chk("busy_fall", 64'(busy_a), 64'd0);
        chk("first_latency", 64'(lat), 64'(v.exp_lat));
        chk("beat_count", 64'(beats), 64'(v.exp_n));
        chk("first_word", 64'(first_d), 64'(v.exp_first));
        chk("last_word", 64'(last_d), 64'(v.exp_last));
        chk("overrun", 64'(ovr_a), 64'(v.exp_ovr));
    endtask

    task automatic reset_mid_sweep();
        bit saw = 0;
        sync_a = 1'b1;
        base_a = 7'd20;
        @(posedge clk); #1;
        sync_a = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_rdaddress", 64'(rdaddr_a), 64'd0);
        chk("rst_col_valid", 64'(valid_a), 64'd0);
        chk("rst_col_last", 64'(last_a), 64'd0);
        chk("rst_col_data", 64'(data_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_overrun", 64'(ovr_a), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid_a || busy_a) saw = 1;
        end
        chk("quiet_after_reset", 64'(saw), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic wrap_test_b();
        int beats = 0;
        logic [35:0] last_d = '0;
        sync_b = 1'b1;
        base_b = 7'd120;
        ready_b = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            sync_b = 1'b0;
            if (k <= 16) chk("wrap_rdaddress", 64'(rdaddr_b), 64'(7'(7'd119 + 7'(k))));
            @(negedge clk);
            if (valid_b && ready_b) begin
                chk("wrap_data", 64'(data_b), 64'(memv(7'(7'd120 + 7'(beats)))));
                chk("wrap_last", 64'(last_b), 64'(beats == 15));
                if (last_b) last_d = data_b;
                beats++;
            end
        end
        chk("wrap_count", 64'(beats), 64'd16);
        chk("wrap_last_word", 64'(last_d), 64'h0A5A5A5A5D);
        chk("wrap_busy_end", 64'(busy_b), 64'd0);
    endtask

    sweep_vec_t vecs [5];

    initial begin
        vecs[0] = '{7'd0,   0, 0,  128, 4, 36'hA5A5A5A5A, 36'hA5A5A5A25, 1'b0};
        vecs[1] = '{7'd0,   0, 0,  128, 4, 36'hA5A5A5A5A, 36'hA5A5A5A25, 1'b0};
        vecs[2] = '{7'd10,  2, 0,  128, 4, 36'hA5A5A5A50, 36'hA5A5A5A53, 1'b0};
        vecs[3] = '{7'd100, 0, 10, 128, 4, 36'hA5A5A5A3E, 36'hA5A5A5A39, 1'b1};
        vecs[4] = '{7'd50,  0, 0,  128, 4, 36'hA5A5A5A68, 36'hA5A5A5A6B, 1'b0};

        rst_n = 1'b0;
        sync_a = 1'b0; sync_b = 1'b0;
        base_a = '0;   base_b = '0;
        ready_a = 1'b1; ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("init_rdaddress", 64'(rdaddr_a), 64'd0);
        chk("init_col_valid", 64'(valid_a), 64'd0);
        chk("init_busy", 64'(busy_a), 64'd0);
        chk("init_overrun", 64'(ovr_a), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // entries 0 and 1 run back to back: the second sync lands the cycle busy falls
        for (int i = 0; i < 5; i++) begin
            if (i == 4) reset_mid_sweep();
            sweep_a(vecs[i]);
        end

        wrap_test_b();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
